mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates the single multi-cycle main memory among three requesters: I-cache miss fill, D-cache miss fill, and D-cache write-through store.
- Sequences 8-word block fills and drives the cache data-array write enables and word index.
- Raises busy so the hazard and stall logic can freeze the pipeline while memory is held.
- Sits between both cache controllers and main memory, alongside the forwarding and hazard logic.

Parameters:
ADDR_W, 16, byte-address width
DATA_W, 16, word width
WORDS, 8, words per cache block (16 bytes)
MEM_LAT, 4, cycles from mem_enable (read) to matching mem_data_valid; memory accepts one read per cycle, pipelined

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ic_miss  in  1  I-cache fill request, level, held until ic_fill_done
ic_miss_addr  in  16  I-side miss byte address
dc_miss  in  1  D-cache fill request, level, held until dc_fill_done
dc_miss_addr  in  16  D-side miss byte address
dc_wr_req  in  1  write-through store request, level, held until dc_wr_ack
dc_wr_addr  in  16  store byte address
dc_wr_data  in  16  store data
mem_enable  out  1  memory access strobe
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  16  memory byte address
mem_wdata  out  16  write data
mem_rdata  in  16  read data
mem_data_valid  in  1  mem_rdata valid this cycle
fill_data  out  16  word to cache data array (= mem_rdata)
fill_word  out  3  word index within block
ic_fill_we  out  1  I-cache data-array write enable
dc_fill_we  out  1  D-cache data-array write enable
ic_fill_done  out  1  one-cycle pulse: I block complete, write tag/valid
dc_fill_done  out  1  one-cycle pulse: D block complete
dc_wr_ack  out  1  one-cycle pulse: store issued
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, WRITE, FILL, DONE. A 1-bit owner register (I/D) is latched on entry to FILL.
- Reset (async, rst_n=0): state IDLE; issue and receive counters 0; owner 0. All outputs are 0 while in IDLE with no valid.
- IDLE arbitration, sampled each cycle, fixed priority dc_miss > dc_wr_req > ic_miss. D side first because it is the older instruction. No preemption once a transaction starts.
  - dc_miss or ic_miss -> FILL; latch base = {addr[15:4], 4'b0000}.
  - dc_wr_req -> WRITE.
- WRITE (exactly 1 cycle): mem_enable=1, mem_wr=1, mem_addr=dc_wr_addr, mem_wdata=dc_wr_data, dc_wr_ack=1. Next state IDLE.
- FILL issue: for issue_cnt 0..WORDS-1, one per cycle, mem_enable=1, mem_wr=0, mem_addr=base+2*issue_cnt. mem_enable drops after 8 issues.
- FILL receive: each mem_data_valid in FILL produces:
  - fill_data=mem_rdata
  - fill_word=recv_cnt
  - the owner's fill_we=1 (combinational with valid)
  - recv_cnt increments.
- After the 8th valid -> DONE.
- DONE (1 cycle): owner's *_fill_done=1. Next state IDLE. A new request is sampled in the following IDLE cycle.
- Timing for a request sampled in IDLE at cycle T:
  - addresses issued T+1..T+8
  - data valid T+1+MEM_LAT..T+8+MEM_LAT
  - done pulse T+9+MEM_LAT
- Boundaries:
  - mem_data_valid outside FILL, or after 8 words received, is ignored (no we, no count).
  - Address bits [3:0] of the miss address are ignored.
  - Base 0xFFF0 issues up to 0xFFFE with no wrap or overflow.
  - A requester dropping its request mid-fill does not abort the fill; it completes and pulses done.
  - Requests arriving while busy are not queued; the requester holds its level.
  - ic_fill_we and dc_fill_we are never high together.
  - Reset mid-fill returns to IDLE immediately, with no done pulse; later in-flight valids are ignored.

Test Plan:
- I-fill: ic_miss=1, addr 0x1234 at T -> mem_addr 0x1230,0x1232,...,0x123E at T+1..T+8; ic_fill_we with fill_word 0..7 at T+5..T+12; ic_fill_done at T+13; dc_fill_we stays 0.
- Contention: ic_miss and dc_miss both rise at T (dc addr 0x4008) -> D fill 0x4000..0x400E first, dc_fill_done at T+13; I addresses start at T+15.
- Store during fill: dc_wr_req (0x2002, 0xBEEF) at T+3 of an I-fill -> no memory write until the IDLE cycle T+14; at T+15 mem_wr=1, addr 0x2002, wdata 0xBEEF, dc_wr_ack=1.
- Priority: dc_miss and dc_wr_req together in IDLE -> FILL first; WRITE follows the fill.
- Reset: rst_n low at T+7 of a fill -> busy=0 and all strobes 0 immediately; valids at T+8..T+12 produce no fill_we and no done pulse.
- Edge: ic_miss at 0xFFFA -> addresses 0xFFF0..0xFFFE. A spurious mem_data_valid in IDLE -> no we.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, the two cache controllers
// and main memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
);
    logic                       ic_miss;
    logic [ADDR_W-1:0]          ic_miss_addr;
    logic                       dc_miss;
    logic [ADDR_W-1:0]          dc_miss_addr;
    logic                       dc_wr_req;
    logic [ADDR_W-1:0]          dc_wr_addr;
    logic [DATA_W-1:0]          dc_wr_data;
    logic                       mem_enable;
    logic                       mem_wr;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic [DATA_W-1:0]          mem_rdata;
    logic                       mem_data_valid;
    logic [DATA_W-1:0]          fill_data;
    logic [$clog2(WORDS)-1:0]   fill_word;
    logic                       ic_fill_we;
    logic                       dc_fill_we;
    logic                       ic_fill_done;
    logic                       dc_fill_done;
    logic                       dc_wr_ack;
    logic                       busy;

    modport master (
        input  ic_miss, ic_miss_addr,
        input  dc_miss, dc_miss_addr,
        input  dc_wr_req, dc_wr_addr, dc_wr_data,
        input  mem_rdata, mem_data_valid,
        output mem_enable, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word,
        output ic_fill_we, dc_fill_we,
        output ic_fill_done, dc_fill_done,
        output dc_wr_ack, busy
    );

    modport slave (
        output ic_miss, ic_miss_addr,
        output dc_miss, dc_miss_addr,
        output dc_wr_req, dc_wr_addr, dc_wr_data,
        output mem_rdata, mem_data_valid,
        input  mem_enable, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word,
        input  ic_fill_we, dc_fill_we,
        input  ic_fill_done, dc_fill_done,
        input  dc_wr_ack, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: D-miss > D-store > I-miss, sequences pipelined
// block fills into the cache data arrays and issues write-through stores.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    localparam int WC = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] BLK_MASK =
        ~ADDR_W'(2 * WORDS - 1);

    typedef enum logic [1:0] {
        IDLE, WRITE, FILL, DONE
    } state_e;

    state_e            state_q;
    logic              owner_q;
    logic [WC:0]       issue_cnt_q;
    logic [WC-1:0]     recv_cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic              mem_enable_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              ack_q;
    logic              ic_done_q;
    logic              dc_done_q;

    logic              rx_vld;
    logic [ADDR_W-1:0] issue_addr_d;
    logic [ADDR_W-1:0] dc_base_d;
    logic [ADDR_W-1:0] ic_base_d;

    // Only valids landing in FILL belong to the current block.
    assign rx_vld = (state_q == FILL) && bus.mem_data_valid;
    assign issue_addr_d =
        base_q + ADDR_W'({issue_cnt_q, 1'b0});
    assign dc_base_d = bus.dc_miss_addr & BLK_MASK;
    assign ic_base_d = bus.ic_miss_addr & BLK_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            base_q       <= '0;
            mem_enable_q <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ack_q        <= 1'b0;
            ic_done_q    <= 1'b0;
            dc_done_q    <= 1'b0;
        end else begin
            mem_enable_q <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ack_q        <= 1'b0;
            ic_done_q    <= 1'b0;
            dc_done_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    issue_cnt_q <= '0;
                    recv_cnt_q  <= '0;
                    if (bus.dc_miss) begin
                        state_q      <= FILL;
                        owner_q      <= 1'b1;
                        base_q       <= dc_base_d;
                        mem_enable_q <= 1'b1;
                        mem_addr_q   <= dc_base_d;
                        issue_cnt_q  <= (WC+1)'(1);
                    end else if (bus.dc_wr_req) begin
                        state_q      <= WRITE;
                        mem_enable_q <= 1'b1;
                        mem_wr_q     <= 1'b1;
                        mem_addr_q   <= bus.dc_wr_addr;
                        mem_wdata_q  <= bus.dc_wr_data;
                        ack_q        <= 1'b1;
                    end else if (bus.ic_miss) begin
                        state_q      <= FILL;
                        owner_q      <= 1'b0;
                        base_q       <= ic_base_d;
                        mem_enable_q <= 1'b1;
                        mem_addr_q   <= ic_base_d;
                        issue_cnt_q  <= (WC+1)'(1);
                    end
                end
                WRITE: state_q <= IDLE;
                FILL: begin
                    if (issue_cnt_q < (WC+1)'(WORDS)) begin
                        mem_enable_q <= 1'b1;
                        mem_addr_q   <= issue_addr_d;
                        issue_cnt_q  <= issue_cnt_q + 1'b1;
                    end
                    if (rx_vld) begin
                        recv_cnt_q <= recv_cnt_q + 1'b1;
                        if (recv_cnt_q == WC'(WORDS - 1)) begin
                            state_q   <= DONE;
                            ic_done_q <= ~owner_q;
                            dc_done_q <= owner_q;
                        end
                    end
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_enable   = mem_enable_q;
    assign bus.mem_wr       = mem_wr_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.fill_data    = rx_vld ? bus.mem_rdata : '0;
    assign bus.fill_word    = rx_vld ? recv_cnt_q : '0;
    assign bus.ic_fill_we   = rx_vld & ~owner_q;
    assign bus.dc_fill_we   = rx_vld & owner_q;
    assign bus.ic_fill_done = ic_done_q;
    assign bus.dc_fill_done = dc_done_q;
    assign bus.dc_wr_ack    = ack_q;
    assign bus.busy         = (state_q != IDLE);
endmodule
